// File: rtl/risc_v_pkg.sv
`default_nettype none
// ============================================================================
// Module : risc_v_pkg
// Brief  : Shared fetch-side definitions. It holds the data width, the NOP
//          encoding and the responder FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package risc_v_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module : imem_array
// Brief  : DEPTH x XLEN instruction storage. Writes are synchronous and reads
//          are combinational. The reader registers the read data.
// Ports  : clk              clock
//          wr_en/wr_addr/wr_data  loader write port, committed on the rising edge
//          rd_addr          read index
//          rd_data          array contents at rd_addr (combinational)
// Rev    : 1.0  initial release
// ============================================================================
module imem_array
  import risc_v_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data
);

  // Contents are deliberately not reset so a boot image survives rst.
  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : instr_mem_responder
// Brief  : Instruction-memory responder for the fetch interface. It accepts a
//          word-indexed PC and waits WAIT_CYCLES wait states. It then returns
//          the instruction through a valid/ready handshake.
// Ports  : clk, rst                  clock, synchronous active-high reset
//          req_valid/req_pc/req_ready  fetch request handshake
//          resp_valid/resp_ready       response handshake
//          resp_instr/resp_err         fetched word, out-of-range flag
//          busy                        request in flight or response pending
//          flush                       drop in-flight request and pending response
//          wr_en/wr_addr/wr_data       loader write port into the array
// Rev    : 1.0  initial release
// ============================================================================
module instr_mem_responder
  import risc_v_pkg::*;
#(
  parameter int              DEPTH       = 256,
  parameter int              AW          = $clog2(DEPTH),
  parameter int              WAIT_CYCLES = 2,
  parameter logic [XLEN-1:0] NOP_INSTR   = RV_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_pc,
  output logic            req_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_instr,
  output logic            resp_err,
  output logic            busy,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam logic [3:0]   WAIT_LOAD    = 4'(WAIT_CYCLES);
  localparam fetch_state_e ACCEPT_STATE = (WAIT_CYCLES == 0) ? RESP : WAIT;

  fetch_state_e    state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_instr_q, resp_instr_d;
  logic            resp_err_q, resp_err_d;

  logic            accept;
  logic [XLEN-1:0] lookup_pc;
  logic            lookup_oor;
  logic [XLEN-1:0] rd_data;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (lookup_pc[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    req_ready = !flush && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
    accept    = req_valid && req_ready;

    // With zero wait states, RESP is entered on the accept edge itself.
    // pc_q is not loaded yet at that point, so the lookup uses req_pc.
    // Later entries come from WAIT, where no accept is possible.
    lookup_pc  = accept ? req_pc : pc_q;
    lookup_oor = (lookup_pc >= XLEN'(DEPTH));

    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;

    if (flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      resp_instr_d = NOP_INSTR;
      resp_err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        pc_d    = req_pc;
        cnt_d   = WAIT_LOAD;
        state_d = ACCEPT_STATE;
      end

      // Capture the response only when RESP is entered or re-entered.
      // A held response must not be overwritten by later loader writes.
      if ((state_d == RESP) && ((state_q != RESP) || accept)) begin
        resp_valid_d = 1'b1;
        resp_instr_d = lookup_oor ? NOP_INSTR : rd_data;
        resp_err_d   = lookup_oor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      pc_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= NOP_INSTR;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_mem_responder
// Brief  : Self-checking bench with two responder instances.
//          dut_w2 runs with WAIT_CYCLES=2. Its expected responses are queued
//          when a request is accepted. They are popped when a response is
//          consumed.
//          dut_w0 runs with WAIT_CYCLES=0. It covers write/read ordering on
//          RESP entry and reset during RESP.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_mem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic        a_req_valid = 1'b0, a_resp_ready = 1'b0;
  logic [31:0] a_req_pc = '0;
  logic        a_req_ready, a_resp_valid, a_resp_err, a_busy;
  logic [31:0] a_resp_instr;

  logic        b_req_valid = 1'b0, b_resp_ready = 1'b0;
  logic [31:0] b_req_pc = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_instr;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] model_mem [256];
  logic [32:0] sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_responder #(.DEPTH(256), .AW(8), .WAIT_CYCLES(2), .NOP_INSTR(NOP)) dut_w2 (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_pc(a_req_pc), .req_ready(a_req_ready),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_instr(a_resp_instr),
    .resp_err(a_resp_err), .busy(a_busy), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  instr_mem_responder #(.DEPTH(256), .AW(8), .WAIT_CYCLES(0), .NOP_INSTR(NOP)) dut_w0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_pc(b_req_pc), .req_ready(b_req_ready),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_instr(b_resp_instr),
    .resp_err(b_resp_err), .busy(b_busy), .flush(1'b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [32:0] exp_of(input logic [31:0] pc);
    if (pc >= 32'd256) return {1'b1, NOP};
    return {1'b0, model_mem[pc[7:0]]};
  endfunction

  // Scoreboard consumer: every consumed dut_w2 response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && a_resp_valid && a_resp_ready) begin
      check_eq("sb_response_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        logic [32:0] e;
        e = sb.pop_front();
        check_eq("sb_instr", a_resp_instr, e[31:0]);
        check_eq("sb_err", a_resp_err, e[32]);
      end
    end
  end

  // Called in the drive phase. Returns in the drive phase of the following cycle.
  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    model_mem[addr] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic fetch_single(input logic [31:0] pc);
    logic [32:0] e;
    e = exp_of(pc);
    a_req_valid = 1'b1; a_req_pc = pc; a_resp_ready = 1'b0;
    @(negedge clk);
    check_eq("accept_ready", a_req_ready, 1);
    if (a_req_ready) sb.push_back(e);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("latency_t%0d_valid", i), a_resp_valid, (i == 3));
      check_eq("busy_in_flight", a_busy, 1);
      if (i < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("hold_valid", a_resp_valid, 1);
    check_eq("hold_instr", a_resp_instr, e[31:0]);
    check_eq("hold_err", a_resp_err, e[32]);
    @(posedge clk); #1;
    a_resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    @(negedge clk);
    check_eq("consumed_valid", a_resp_valid, 0);
    check_eq("consumed_busy", a_busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_rsp, last;

    // Reset and idle state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", a_resp_valid, 0);
    check_eq("rst_instr", a_resp_instr, NOP);
    check_eq("rst_err", a_resp_err, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_ready", a_req_ready, 1);
    check_eq("rst_w0_instr", b_resp_instr, NOP);
    @(posedge clk); #1;

    // Boot image: addi x1, x0, i at word i.
    for (int i = 0; i < 16; i++) load(8'(i), (32'(i) << 20) | 32'h93);
    load(8'd255, 32'hDEAD_B00F);

    // Single fetch with fixed latency and hold.
    fetch_single(32'd5);
    check_eq("model_word5", model_mem[5], 32'h0050_0093);
    fetch_single(32'd255);
    fetch_single(32'h0000_0100);
    fetch_single(32'h8000_0005);

    // Back-to-back stream of requests: pcs 0, 1, 2, one response every 3 cycles.
    a_req_valid = 1'b1; a_req_pc = 32'd0; a_resp_ready = 1'b1;
    n_acc = 0; n_rsp = 0; last = 0;
    for (int c = 0; c < 40 && n_rsp < 3; c++) begin
      @(negedge clk);
      if (a_resp_valid) begin
        if (n_rsp > 0) check_eq("b2b_gap", 64'(cyc - last), 64'd3);
        last = cyc;
        n_rsp++;
      end
      if (a_req_valid && a_req_ready) begin
        sb.push_back(exp_of(a_req_pc));
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc >= 3) a_req_valid = 1'b0;
      else a_req_pc = 32'(n_acc);
    end
    check_eq("b2b_count", 64'(n_rsp), 64'd3);
    a_req_valid = 1'b0; a_resp_ready = 1'b0;
    @(posedge clk); #1;

    // Flush during WAIT. A request presented in the flush cycle must be ignored.
    a_req_valid = 1'b1; a_req_pc = 32'd7;
    @(negedge clk);
    check_eq("flush_pre_ready", a_req_ready, 1);
    @(posedge clk); #1;
    a_req_pc = 32'd8; flush = 1'b1;
    @(negedge clk);
    check_eq("flush_req_ready", a_req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; a_req_valid = 1'b0; a_resp_ready = 1'b1;
    @(negedge clk);
    check_eq("flush_busy", a_busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("flush_no_resp", a_resp_valid, 0);
    end
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    fetch_single(32'd9);

    // Flush while a response is held. The pending response is dropped.
    a_req_valid = 1'b1; a_req_pc = 32'd4;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_eq("resp_flush_pre_valid", a_resp_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("resp_flush_valid", a_resp_valid, 0);
    check_eq("resp_flush_instr", a_resp_instr, NOP);
    check_eq("resp_flush_busy", a_busy, 0);
    @(posedge clk); #1;

    // WAIT_CYCLES=0 instance. A write in the cycle before RESP entry is visible.
    // A write on the entry edge is not visible.
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'hAAAA_0001;
    @(posedge clk); #1;
    wr_data = 32'hBBBB_0002;
    b_req_valid = 1'b1; b_req_pc = 32'd3;
    @(negedge clk);
    check_eq("w0_ready", b_req_ready, 1);
    @(posedge clk); #1;
    wr_en = 1'b0; b_req_valid = 1'b0;
    @(negedge clk);
    check_eq("w0_valid_lat1", b_resp_valid, 1);
    check_eq("w0_instr_ordering", b_resp_instr, 32'hAAAA_0001);
    check_eq("w0_err", b_resp_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("w0_rst_valid", b_resp_valid, 0);
    check_eq("w0_rst_instr", b_resp_instr, NOP);
    check_eq("w0_rst_busy", b_busy, 0);
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_pc = 32'd3;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    check_eq("w0_preserved_valid", b_resp_valid, 1);
    check_eq("w0_preserved_instr", b_resp_instr, 32'hBBBB_0002);
    @(posedge clk); #1;
    b_resp_ready = 1'b1;
    @(posedge clk); #1;
    b_resp_ready = 1'b0;
    @(negedge clk);
    check_eq("w0_consumed_valid", b_resp_valid, 0);

    check_eq("sb_leftover", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
